// File: rtl/pcu_trig_pkg.sv
// Shared types and encoding helpers for the PCU trigger master.
package pcu_trig_pkg;

  localparam int unsigned SECTION_W      = 2;
  localparam int unsigned SECTION_STRIDE = 4;
  localparam int unsigned STOP_OFS       = 0;
  localparam int unsigned GO_OFS         = 1;
  localparam logic [31:0] CLEAR_DATA     = 32'h1;

  typedef enum logic [1:0] {
    OP_STOP  = 2'd0,
    OP_GO    = 2'd1,
    OP_CLEAR = 2'd2
  } op_e;

  typedef struct packed {
    op_e                  op;
    logic [SECTION_W-1:0] section;
  } cmd_t;

  // Slave word address targeted by a command.
  function automatic logic [31:0] cmd_addr(cmd_t c);
    logic [31:0] base;
    base = 32'(c.section) * 32'(SECTION_STRIDE);
    case (c.op)
      OP_STOP: cmd_addr = base + 32'(STOP_OFS);
      OP_GO:   cmd_addr = base + 32'(GO_OFS);
      default: cmd_addr = 32'(0);
    endcase
  endfunction

  // Write data carried by a command; only a global clear writes non-zero.
  function automatic logic [31:0] cmd_data(cmd_t c);
    cmd_data = (c.op == OP_CLEAR) ? CLEAR_DATA : 32'(0);
  endfunction

endpackage

// File: rtl/pcu_trig_fifo.sv
// Synchronous command FIFO with registered full/empty/level flags.
module pcu_trig_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_nxt;

  // Push into a full FIFO is accepted only when a pop frees the slot that same cycle.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign level_nxt = LW'(level + LW'(do_push) - LW'(do_pop));
  assign rdata_c   = mem[rd_ptr];

  // Pointers, occupancy and flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (do_pop)  rd_ptr <= AW'(rd_ptr + 1'b1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pcu_trigger_master.sv
// Turns per-section start/stop/clear pulses into Avalon-MM writes to the counter unit.
module pcu_trigger_master
  import pcu_trig_pkg::*;
#(
  parameter int unsigned NUM_SECTIONS = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SECTIONS-1:0]       start_evt,
  input  logic [NUM_SECTIONS-1:0]       stop_evt,
  input  logic                          clear_evt,
  input  logic                          clear_overflow,
  output logic [ADDR_W-1:0]             avm_address,
  output logic                          avm_write,
  output logic                          avm_begintransfer,
  output logic [31:0]                   avm_writedata,
  input  logic                          avm_waitrequest,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PEND_W = 2 * NUM_SECTIONS + 1;
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CMD_W  = $bits(cmd_t);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  // Pending bit layout: [0] clear, [1..N] stop[s], [N+1..2N] start[s]; lower index wins.
  logic [PEND_W-1:0] pend;
  logic [PEND_W-1:0] pend_nxt;
  logic [PEND_W-1:0] evt;
  logic [PEND_W-1:0] sel;
  logic [PEND_W-1:0] deq;
  logic              found;
  logic              push;
  logic              pop;
  logic              loss;
  logic              full;
  logic              empty;
  cmd_t              sel_cmd;
  cmd_t              head;
  logic [CMD_W-1:0]  head_bits;
  logic [LVL_W-1:0]  lvl_nxt;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       data_nxt;
  logic              write_nxt;
  logic              bt_nxt;

  assign evt  = {start_evt, stop_evt, clear_evt};
  assign push = found && !full;
  assign head = cmd_t'(head_bits);

  // Fixed-priority selection of the next pending event to enqueue.
  always_comb begin
    found           = 1'b0;
    sel             = '0;
    sel_cmd.op      = OP_CLEAR;
    sel_cmd.section = '0;
    for (int unsigned i = 0; i < PEND_W; i++) begin
      if (!found && pend[i]) begin
        found  = 1'b1;
        sel[i] = 1'b1;
        if (i == 0) begin
          sel_cmd.op      = OP_CLEAR;
          sel_cmd.section = '0;
        end else if (i <= NUM_SECTIONS) begin
          sel_cmd.op      = OP_STOP;
          sel_cmd.section = SECTION_W'(i - 1);
        end else begin
          sel_cmd.op      = OP_GO;
          sel_cmd.section = SECTION_W'(i - 1 - NUM_SECTIONS);
        end
      end
    end
  end

  // Pending update: a repeated pulse on a bit that is not leaving this cycle is lost.
  always_comb begin
    deq      = sel & {PEND_W{push}};
    pend_nxt = (pend & ~deq) | evt;
    loss     = |(evt & pend & ~deq);
  end

  // Pending bits and sticky overflow; a loss beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (loss)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  pcu_trig_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wdata   (sel_cmd),
    .pop     (pop),
    .rdata_c (head_bits),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // Transfer FSM next state and next output values; head stays queued until completion.
  always_comb begin
    state_nxt = state;
    addr_nxt  = avm_address;
    data_nxt  = avm_writedata;
    write_nxt = avm_write;
    bt_nxt    = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_nxt = ST_XFER;
          addr_nxt  = ADDR_W'(cmd_addr(head));
          data_nxt  = cmd_data(head);
          write_nxt = 1'b1;
          bt_nxt    = 1'b1;
        end
      end
      ST_XFER: begin
        if (!avm_waitrequest) begin
          pop       = 1'b1;
          write_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Occupancy after this edge, used so busy reflects the post-edge state.
  assign lvl_nxt = LVL_W'(fifo_level + LVL_W'(push) - LVL_W'(pop && !empty));

  // State register and registered bus/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      avm_address       <= '0;
      avm_writedata     <= '0;
      avm_write         <= 1'b0;
      avm_begintransfer <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_nxt;
      avm_address       <= addr_nxt;
      avm_writedata     <= data_nxt;
      avm_write         <= write_nxt;
      avm_begintransfer <= bt_nxt;
      busy              <= (|pend_nxt) || (lvl_nxt != '0) || (state_nxt == ST_XFER);
    end
  end

endmodule

// File: tb/tb_pcu_trigger_master.sv
// Scoreboard bench for pcu_trigger_master with a queue-based reference model.
module tb_pcu_trigger_master;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  start_evt;
  logic [N-1:0]  stop_evt;
  logic          clear_evt;
  logic          clear_overflow;
  logic [AW-1:0] avm_address;
  logic          avm_write;
  logic          avm_begintransfer;
  logic [31:0]   avm_writedata;
  logic          avm_waitrequest;
  logic          busy;
  logic          overflow;
  logic [3:0]    fifo_level;

  always #5 clk = ~clk;

  pcu_trigger_master #(
    .NUM_SECTIONS (N),
    .FIFO_DEPTH   (D),
    .ADDR_W       (AW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start_evt         (start_evt),
    .stop_evt          (stop_evt),
    .clear_evt         (clear_evt),
    .clear_overflow    (clear_overflow),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_begintransfer (avm_begintransfer),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .busy              (busy),
    .overflow          (overflow),
    .fifo_level        (fifo_level)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  // Reference model state: which events are waiting, queued commands, transfer in progress.
  bit   m_clr;
  bit   m_stop  [N];
  bit   m_start [N];
  int   m_fifo  [$];
  bit   m_xfer;
  bit   m_bt;
  bit   m_ovf;
  wr_t  exp_q   [$];

  int   checks   = 0;
  int   errors   = 0;
  int   n_writes = 0;
  bit   mon_en   = 1'b0;
  int   cur_addr = 0;
  int   cur_data = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one step per clock edge using the inputs seen at that edge.
  always @(posedge clk) begin : model_p
    int  sz0;
    int  kind;
    int  pick;
    bit  lose;
    wr_t w;
    if (reset) begin
      m_clr = 1'b0;
      for (int s = 0; s < N; s++) begin
        m_stop[s]  = 1'b0;
        m_start[s] = 1'b0;
      end
      m_fifo.delete();
      exp_q.delete();
      m_xfer = 1'b0;
      m_bt   = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      sz0  = m_fifo.size();
      kind = -1;
      pick = 0;
      if (sz0 < D) begin
        if (m_clr) kind = 0;
        for (int s = 0; s < N; s++)
          if (kind < 0 && m_stop[s]) begin kind = 1; pick = s; end
        for (int s = 0; s < N; s++)
          if (kind < 0 && m_start[s]) begin kind = 2; pick = s; end
      end
      lose = 1'b0;
      if (clear_evt && m_clr && kind != 0) lose = 1'b1;
      for (int s = 0; s < N; s++) begin
        if (stop_evt[s]  && m_stop[s]  && !(kind == 1 && pick == s)) lose = 1'b1;
        if (start_evt[s] && m_start[s] && !(kind == 2 && pick == s)) lose = 1'b1;
      end
      if (kind == 0) m_clr = 1'b0;
      if (kind == 1) m_stop[pick] = 1'b0;
      if (kind == 2) m_start[pick] = 1'b0;
      if (clear_evt) m_clr = 1'b1;
      for (int s = 0; s < N; s++) begin
        if (stop_evt[s])  m_stop[s]  = 1'b1;
        if (start_evt[s]) m_start[s] = 1'b1;
      end
      m_bt = 1'b0;
      if (m_xfer) begin
        if (!avm_waitrequest) begin
          m_fifo.delete(0);
          m_xfer = 1'b0;
        end
      end else if (sz0 > 0) begin
        m_xfer = 1'b1;
        m_bt   = 1'b1;
      end
      if (kind >= 0) begin
        m_fifo.push_back(kind);
        w.addr = (kind == 0) ? 0 : 4 * pick + ((kind == 2) ? 1 : 0);
        w.data = (kind == 0) ? 1 : 0;
        exp_q.push_back(w);
      end
      if (lose) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
    end
  end

  // Monitor: status every cycle; each new write pops the scoreboard, held writes stay stable.
  always @(negedge clk) begin : monitor_p
    bit  exp_busy;
    wr_t w;
    if (mon_en) begin
      exp_busy = m_clr || (m_fifo.size() > 0) || m_xfer;
      for (int s = 0; s < N; s++) exp_busy = exp_busy || m_stop[s] || m_start[s];
      check("avm_write", 32'(avm_write), 32'(m_xfer));
      check("avm_begintransfer", 32'(avm_begintransfer), 32'(m_bt));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
      check("busy", 32'(busy), 32'(exp_busy));
      if (avm_begintransfer) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d with nothing expected at %0t", avm_address, $time);
        end else begin
          w = exp_q.pop_front();
          cur_addr = w.addr;
          cur_data = w.data;
        end
      end
      if (avm_write) begin
        check("avm_address", 32'(avm_address), 32'(cur_addr));
        check("avm_writedata", avm_writedata, 32'(cur_data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [N-1:0] st, input logic [N-1:0] sp, input logic cl);
    start_evt = st;
    stop_evt  = sp;
    clear_evt = cl;
    @(negedge clk);
    start_evt = '0;
    stop_evt  = '0;
    clear_evt = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", 32'(busy), 32'(0));
  endtask

  initial begin
    int base;
    int hi;
    reset           = 1'b1;
    start_evt       = '0;
    stop_evt        = '0;
    clear_evt       = 1'b0;
    clear_overflow  = 1'b0;
    avm_waitrequest = 1'b0;
    tick(3);
    mon_en = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);

    // Single GO to section 2, latency and one write.
    base = n_writes;
    pulse(4'b0100, 4'b0000, 1'b0);
    tick(1);
    check("latency_e1", 32'(avm_write), 32'(0));
    tick(1);
    check("latency_e2", 32'(avm_write), 32'(1));
    check("latency_addr", 32'(avm_address), 32'(9));
    wait_idle(50);
    check("single_write_count", 32'(n_writes - base), 32'(1));

    // Simultaneous starts and stop[0].
    base = n_writes;
    pulse(4'b1111, 4'b0001, 1'b0);
    wait_idle(100);
    check("burst_write_count", 32'(n_writes - base), 32'(5));
    check("burst_overflow", 32'(overflow), 32'(0));

    // Clear together with stop[1].
    base = n_writes;
    pulse(4'b0000, 4'b0010, 1'b1);
    wait_idle(50);
    check("clear_write_count", 32'(n_writes - base), 32'(2));

    // Stalled GO to section 3.
    avm_waitrequest = 1'b1;
    pulse(4'b1000, 4'b0000, 1'b0);
    hi = 0;
    for (int c = 0; c < 20 && !avm_write; c++) tick(1);
    while (avm_write && hi < 6) begin
      hi++;
      if (hi == 6) avm_waitrequest = 1'b0;
      tick(1);
    end
    check("stall_write_cycles", 32'(hi), 32'(6));
    check("stall_released", 32'(avm_write), 32'(0));
    wait_idle(50);

    // Fill FIFO under stall, hold a stop pending, then lose a duplicate.
    base = n_writes;
    avm_waitrequest = 1'b1;
    pulse(4'b1111, 4'b1110, 1'b1);
    tick(10);
    check("fill_level", 32'(fifo_level), 32'(8));
    pulse(4'b0000, 4'b0001, 1'b0);
    tick(2);
    check("held_no_overflow", 32'(overflow), 32'(0));
    pulse(4'b0000, 4'b0001, 1'b0);
    check("dup_overflow", 32'(overflow), 32'(1));
    check("dup_level", 32'(fifo_level), 32'(8));
    avm_waitrequest = 1'b0;
    wait_idle(200);
    check("fill_write_count", 32'(n_writes - base), 32'(9));
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("overflow_cleared", 32'(overflow), 32'(0));

    // Reset in the middle of a stalled transfer with three queued.
    avm_waitrequest = 1'b1;
    pulse(4'b0111, 4'b0000, 1'b0);
    tick(4);
    check("pre_reset_level", 32'(fifo_level), 32'(3));
    check("pre_reset_write", 32'(avm_write), 32'(1));
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("reset_write", 32'(avm_write), 32'(0));
    check("reset_level", 32'(fifo_level), 32'(0));
    base = n_writes;
    avm_waitrequest = 1'b0;
    tick(20);
    check("reset_no_writes", 32'(n_writes - base), 32'(0));

    // Randomized traffic with random stalls and overflow clears.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        start_evt[b] = ($urandom_range(0, 11) == 0);
        stop_evt[b]  = ($urandom_range(0, 11) == 0);
      end
      clear_evt       = ($urandom_range(0, 29) == 0);
      clear_overflow  = ($urandom_range(0, 19) == 0);
      avm_waitrequest = ($urandom_range(0, 2) == 0);
      tick(1);
    end
    start_evt       = '0;
    stop_evt        = '0;
    clear_evt       = 1'b0;
    clear_overflow  = 1'b0;
    avm_waitrequest = 1'b0;
    wait_idle(300);
    tick(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
